// File: rtl/tlb_miss_handler_pkg.sv
// Shared types for the user-mode TLB miss walker: address geometry, PTE and TLB fill formats, walker states.
// Latency: n/a (types and a pure address helper only).
// Backpressure: n/a.
package tlb_miss_handler_pkg;

  localparam int VIRT_ADDR_WIDTH    = 32;
  localparam int PHY_ADDR_WIDTH     = 32;
  localparam int THR_PER_CORE_WIDTH = 2;

  // Virtual address split: [tag | page offset]
  localparam int VIRT_ADDR_OFFSET_MSB = 11;
  localparam int VIRT_ADDR_OFFSET_LSB = 0;
  localparam int VIRT_ADDR_TAG_MSB    = VIRT_ADDR_WIDTH - 1;
  localparam int VIRT_ADDR_TAG_LSB    = VIRT_ADDR_OFFSET_MSB + 1;
  localparam int PAGE_OFFSET_WIDTH    = VIRT_ADDR_OFFSET_MSB - VIRT_ADDR_OFFSET_LSB + 1;
  localparam int VIRT_TAG_WIDTH       = VIRT_ADDR_TAG_MSB - VIRT_ADDR_TAG_LSB + 1;
  localparam int PPN_WIDTH            = PHY_ADDR_WIDTH - PAGE_OFFSET_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [PPN_WIDTH-1:0] ppn;
  } pte_t;

  typedef struct packed {
    logic [VIRT_ADDR_WIDTH-1:0] virt_addr;
    logic [PHY_ADDR_WIDTH-1:0]  phy_addr;
  } tlb_req_info_t;

  typedef enum logic [2:0] {
    WALK_IDLE  = 3'd0,
    WALK_REQ   = 3'd1,
    WALK_WAIT  = 3'd2,
    WALK_FILL  = 3'd3,
    WALK_FAULT = 3'd4,
    WALK_DRAIN = 3'd5
  } walker_state_t;

  // One 4-byte PTE per virtual page; the sum wraps silently at the physical address width.
  function automatic logic [PHY_ADDR_WIDTH-1:0] pte_addr(
    input logic [PHY_ADDR_WIDTH-1:0]  base,
    input logic [VIRT_ADDR_WIDTH-1:0] va
  );
    logic [VIRT_TAG_WIDTH+1:0] idx;
    idx = {va[VIRT_ADDR_TAG_MSB:VIRT_ADDR_TAG_LSB], 2'b00};
    return base + PHY_ADDR_WIDTH'(idx);
  endfunction

endpackage

// File: rtl/tlb_miss_handler.sv
// Single-level page-table walker: accepts one TLB miss, reads its PTE, then fills the TLB or reports a page fault.
// Latency: miss accepted cycle 0, PTE request cycle 1, response earliest cycle 2, fill/fault pulse cycle 3.
// Backpressure: miss_ready only in IDLE without flush; request held until mem_req_ready; responses never stalled.
//
// Ports: clk/rst_n (async active-low); miss_valid/miss_ready/miss_thread_id/miss_virt_addr + ptbr (miss intake);
// flush (abort walk); mem_req_valid/ready/addr (PTE read); mem_rsp_valid/data (PTE response);
// new_tlb_entry/new_tlb_thread_id/new_tlb_info (fill pulse); page_fault/page_fault_virt_addr (fault pulse); busy.
module tlb_miss_handler
  import tlb_miss_handler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_valid,
  input  logic [THR_PER_CORE_WIDTH-1:0] miss_thread_id,
  input  logic [VIRT_ADDR_WIDTH-1:0]    miss_virt_addr,
  output logic                          miss_ready,
  input  logic [PHY_ADDR_WIDTH-1:0]     ptbr,
  input  logic                          flush,
  output logic                          mem_req_valid,
  output logic [PHY_ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  pte_t                          mem_rsp_data,
  output logic                          new_tlb_entry,
  output logic [THR_PER_CORE_WIDTH-1:0] new_tlb_thread_id,
  output tlb_req_info_t                 new_tlb_info,
  output logic                          page_fault,
  output logic [VIRT_ADDR_WIDTH-1:0]    page_fault_virt_addr,
  output logic                          busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  walker_state_t                 state;
  logic [VIRT_ADDR_WIDTH-1:0]    cap_va;
  logic [THR_PER_CORE_WIDTH-1:0] cap_tid;
  logic [CNT_W-1:0]              tmo_cnt;
  logic                          timeout_hit;

  // Fires in the last of TIMEOUT_CYCLES response-less WAIT/DRAIN cycles.
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign miss_ready = (state == WALK_IDLE) && !flush;
  assign busy       = (state != WALK_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= WALK_IDLE;
      cap_va               <= '0;
      cap_tid              <= '0;
      tmo_cnt              <= '0;
      mem_req_valid        <= 1'b0;
      mem_req_addr         <= '0;
      new_tlb_entry        <= 1'b0;
      new_tlb_thread_id    <= '0;
      new_tlb_info         <= '0;
      page_fault           <= 1'b0;
      page_fault_virt_addr <= '0;
    end else begin
      new_tlb_entry <= 1'b0;
      page_fault    <= 1'b0;
      case (state)
        WALK_IDLE: begin
          if (miss_valid && !flush) begin
            cap_va        <= miss_virt_addr;
            cap_tid       <= miss_thread_id;
            mem_req_addr  <= pte_addr(ptbr, miss_virt_addr);
            mem_req_valid <= 1'b1;
            state         <= WALK_REQ;
          end
        end
        WALK_REQ: begin
          if (mem_req_ready) begin
            // A handshake that coincides with flush still has a response in flight, so it must be drained.
            mem_req_valid <= 1'b0;
            tmo_cnt       <= '0;
            state         <= flush ? WALK_DRAIN : WALK_WAIT;
          end else if (flush) begin
            mem_req_valid <= 1'b0;
            state         <= WALK_IDLE;
          end
        end
        WALK_WAIT: begin
          if (flush) begin
            tmo_cnt <= '0;
            state   <= mem_rsp_valid ? WALK_IDLE : WALK_DRAIN;
          end else if (mem_rsp_valid && mem_rsp_data.valid) begin
            new_tlb_entry          <= 1'b1;
            new_tlb_thread_id      <= cap_tid;
            new_tlb_info.virt_addr <= cap_va;
            new_tlb_info.phy_addr  <= {mem_rsp_data.ppn, cap_va[VIRT_ADDR_OFFSET_MSB:VIRT_ADDR_OFFSET_LSB]};
            state                  <= WALK_FILL;
          end else if (mem_rsp_valid || timeout_hit) begin
            page_fault           <= 1'b1;
            page_fault_virt_addr <= cap_va;
            state                <= WALK_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WALK_DRAIN: begin
          if (mem_rsp_valid || timeout_hit) begin
            state <= WALK_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // Pulse cycles; flush here cannot retract the pulse already on the outputs.
        WALK_FILL, WALK_FAULT: state <= WALK_IDLE;
        default:               state <= WALK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_miss_handler.sv
module tb_tlb_miss_handler;
  import tlb_miss_handler_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          miss_valid;
  logic [THR_PER_CORE_WIDTH-1:0] miss_thread_id;
  logic [VIRT_ADDR_WIDTH-1:0]    miss_virt_addr;
  logic                          miss_ready;
  logic [PHY_ADDR_WIDTH-1:0]     ptbr;
  logic                          flush;
  logic                          mem_req_valid;
  logic [PHY_ADDR_WIDTH-1:0]     mem_req_addr;
  logic                          mem_req_ready;
  logic                          mem_rsp_valid;
  pte_t                          mem_rsp_data;
  logic                          new_tlb_entry;
  logic [THR_PER_CORE_WIDTH-1:0] new_tlb_thread_id;
  tlb_req_info_t                 new_tlb_info;
  logic                          page_fault;
  logic [VIRT_ADDR_WIDTH-1:0]    page_fault_virt_addr;
  logic                          busy;

  int checks = 0;
  int errors = 0;

  tlb_miss_handler #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_thread_id(miss_thread_id), .miss_virt_addr(miss_virt_addr),
    .miss_ready(miss_ready), .ptbr(ptbr), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .new_tlb_entry(new_tlb_entry), .new_tlb_thread_id(new_tlb_thread_id), .new_tlb_info(new_tlb_info),
    .page_fault(page_fault), .page_fault_virt_addr(page_fault_virt_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] base;
    logic [1:0]  tid;
    logic        pte_vld;
    logic [19:0] ppn;
    int          delay;     // cycles mem_req_ready stays low
    logic [31:0] exp_addr;
    logic        exp_fill;
    logic [31:0] exp_phy;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_miss(input logic [31:0] va, input logic [31:0] base, input logic [1:0] tid);
    check("idle_miss_ready", miss_ready, 1);
    check("idle_busy", busy, 0);
    miss_valid = 1'b1; miss_virt_addr = va; ptbr = base; miss_thread_id = tid;
    step();
    miss_valid = 1'b0; miss_virt_addr = '0; ptbr = '0;
  endtask

  task automatic run_vec(input vec_t v);
    accept_miss(v.va, v.base, v.tid);
    check("req_miss_ready", miss_ready, 0);
    for (int k = 0; k <= v.delay; k++) begin
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, v.exp_addr);
      mem_req_ready = (k == v.delay);
      step();
    end
    mem_req_ready = 1'b0;
    check("wait_req_valid", mem_req_valid, 0);
    check("wait_busy", busy, 1);
    mem_rsp_valid = 1'b1; mem_rsp_data.valid = v.pte_vld; mem_rsp_data.ppn = v.ppn;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    check("pulse_fill", new_tlb_entry, v.exp_fill);
    check("pulse_fault", page_fault, !v.exp_fill);
    if (v.exp_fill) begin
      check("fill_tid", new_tlb_thread_id, v.tid);
      check("fill_va", new_tlb_info.virt_addr, v.va);
      check("fill_pa", new_tlb_info.phy_addr, v.exp_phy);
    end else begin
      check("fault_va", page_fault_virt_addr, v.va);
    end
    step();
    check("after_fill", new_tlb_entry, 0);
    check("after_fault", page_fault, 0);
    check("after_busy", busy, 0);
  endtask

  // Accept a miss and complete the request handshake immediately; returns in the first WAIT cycle.
  task automatic to_wait(input logic [31:0] va, input logic [31:0] base);
    accept_miss(va, base, 2'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{va:32'h0000_3ABC, base:32'h0000_1000, tid:2'd1, pte_vld:1'b1, ppn:20'h00005, delay:0,
                exp_addr:32'h0000_100C, exp_fill:1'b1, exp_phy:32'h0000_5ABC};
    vecs[1] = '{va:32'hFFFF_F123, base:32'hFFFF_F000, tid:2'd3, pte_vld:1'b1, ppn:20'hABCDE, delay:0,
                exp_addr:32'h003F_EFFC, exp_fill:1'b1, exp_phy:32'hABCD_E123};
    vecs[2] = '{va:32'h1234_5678, base:32'h0020_0000, tid:2'd2, pte_vld:1'b0, ppn:20'h00077, delay:0,
                exp_addr:32'h0024_8D14, exp_fill:1'b0, exp_phy:32'h0};
    vecs[3] = '{va:32'h0000_1000, base:32'h0000_0000, tid:2'd0, pte_vld:1'b1, ppn:20'hFFFFF, delay:5,
                exp_addr:32'h0000_0004, exp_fill:1'b1, exp_phy:32'hFFFF_F000};
    vecs[4] = '{va:32'h0000_0FFF, base:32'h8000_0000, tid:2'd1, pte_vld:1'b1, ppn:20'h00001, delay:2,
                exp_addr:32'h8000_0000, exp_fill:1'b1, exp_phy:32'h0000_1FFF};

    rst_n = 1'b0; miss_valid = 1'b0; miss_thread_id = '0; miss_virt_addr = '0; ptbr = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #12;
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_fill", new_tlb_entry, 0);
    check("rst_fault", page_fault, 0);
    check("rst_busy", busy, 0);
    check("rst_miss_ready", miss_ready, 1);
    check("rst_info", new_tlb_info, 0);
    check("rst_tid", new_tlb_thread_id, 0);
    check("rst_pf_va", page_fault_virt_addr, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Flush in WAIT, response three cycles later: nothing reported, back to IDLE.
    to_wait(32'h0000_3ABC, 32'h0000_1000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain_busy", busy, 1);
    check("drain_miss_ready", miss_ready, 0);
    step();
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data.valid = 1'b1; mem_rsp_data.ppn = 20'h00005;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    check("drain_no_fill", new_tlb_entry, 0);
    check("drain_no_fault", page_fault, 0);
    check("drain_idle", busy, 0);
    run_vec(vecs[0]);

    // No response: fault after 64 WAIT cycles; late response ignored.
    to_wait(32'h0000_7123, 32'h0000_2000);
    for (int i = 0; i < 64; i++) begin
      check("tmo_no_early_fault", page_fault, 0);
      step();
    end
    check("tmo_fault", page_fault, 1);
    check("tmo_fault_va", page_fault_virt_addr, 32'h0000_7123);
    mem_rsp_valid = 1'b1; mem_rsp_data.valid = 1'b1; mem_rsp_data.ppn = 20'h00009;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    check("tmo_late_no_fill", new_tlb_entry, 0);
    check("tmo_late_no_fault", page_fault, 0);
    check("tmo_idle", busy, 0);

    // Flush while the request is still stalled: request withdrawn, miss_ready gated by flush in IDLE.
    accept_miss(32'h0000_5000, 32'h0000_0100, 2'd2);
    flush = 1'b1;
    check("reqflush_miss_ready", miss_ready, 0);
    step();
    check("reqflush_req_valid", mem_req_valid, 0);
    check("reqflush_idle", busy, 0);
    check("reqflush_flush_gates_ready", miss_ready, 0);
    flush = 1'b0;
    #1;
    check("reqflush_ready_back", miss_ready, 1);

    // Reset in WAIT: outputs return to reset values at once; the stale response is ignored.
    to_wait(32'h0000_3ABC, 32'h0000_1000);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_miss_ready", miss_ready, 1);
    check("midrst_req_addr", mem_req_addr, 0);
    check("midrst_info", new_tlb_info, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data.valid = 1'b1; mem_rsp_data.ppn = 20'h00005;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    check("midrst_no_fill", new_tlb_entry, 0);
    check("midrst_no_fault", page_fault, 0);
    check("midrst_ready_after", miss_ready, 1);
    run_vec(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_miss_handler.md
TLB_MISS_HANDLER -- requirements
Module: tlb_miss_handler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: WAIT/DRAIN cycles without mem_rsp_valid before the walk is abandoned.
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-004 miss_valid  in  1  TLB reports a user-mode miss.
REQ-005 miss_thread_id  in  THR_PER_CORE_WIDTH  thread of the miss.
REQ-006 miss_virt_addr  in  VIRT_ADDR width  missing virtual address.
REQ-007 miss_ready  out  1  walker accepts a miss this cycle.
REQ-008 ptbr  in  PHY_ADDR width  page-table base; sampled at miss acceptance.
REQ-009 flush  in  1  abort any walk in progress.
REQ-010 mem_req_valid  out  1; mem_req_addr  out  PHY_ADDR width; mem_req_ready  in  1: PTE read request, valid/ready.
REQ-011 mem_rsp_valid  in  1; mem_rsp_data  in  pte_t: PTE read response, no backpressure.
REQ-012 new_tlb_entry  out  1; new_tlb_thread_id  out  THR_PER_CORE_WIDTH; new_tlb_info  out  tlb_req_info_t: TLB fill, one-cycle pulse.
REQ-013 page_fault  out  1; page_fault_virt_addr  out  VIRT_ADDR width: fault report, one-cycle pulse.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, FILL, FAULT, DRAIN.
REQ-016 IDLE: miss_ready = !flush; miss_valid & miss_ready captures thread, VA, ptbr; next state REQ.
REQ-017 PTE address = ptbr + {VA[VIRT_ADDR_TAG_RANGE], 2'b00}, truncated to PHY_ADDR width (wrap-around, no carry-out flag).
REQ-018 REQ: mem_req_valid = 1, mem_req_addr stable until mem_req_ready; on handshake -> WAIT; flush before handshake -> IDLE, no request issued.
REQ-019 WAIT: on mem_rsp_valid, pte.valid = 1 -> FILL, else -> FAULT; flush -> DRAIN; flush and mem_rsp_valid in the same cycle: response discarded -> IDLE.
REQ-020 DRAIN: next mem_rsp_valid discarded -> IDLE; no fill, no fault.
REQ-021 Timeout counter resets on WAIT/DRAIN entry; at TIMEOUT_CYCLES: WAIT -> FAULT, DRAIN -> IDLE.
REQ-022 FILL: new_tlb_entry = 1 for exactly one cycle; new_tlb_info.virt_addr = captured VA; new_tlb_info.phy_addr = {pte.ppn, VA[VIRT_ADDR_OFFSET_RANGE]}; -> IDLE.
REQ-023 FAULT: page_fault = 1 for one cycle, page_fault_virt_addr = captured VA; -> IDLE.
REQ-024 Flush in FILL or FAULT is ignored; pulse still issued.
REQ-025 mem_rsp_valid outside WAIT/DRAIN is ignored.
REQ-026 Minimum latency: miss accepted cycle 0, mem_req_valid cycle 1 (ready same cycle), rsp cycle 2, new_tlb_entry cycle 3.
REQ-027 One walk at a time; miss_ready = 0 outside IDLE.

Reset
REQ-028 Reset asserted: state IDLE; mem_req_valid, new_tlb_entry, page_fault, busy = 0; miss_ready = 1; mem_req_addr, new_tlb_info, new_tlb_thread_id, page_fault_virt_addr = 0; timeout counter = 0.
REQ-029 Reset mid-walk abandons the walk; a response arriving after reset release is ignored per REQ-025.

Structure
REQ-030 pte_t {valid, ppn} and walker_state_t belong in the shared package beside tlb_req_info_t; widths derive from existing VIRT/PHY range macros.
REQ-031 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-032 Miss VA=0x0000_3ABC, ptbr=0x1000, PTE{valid=1, ppn=0x5} -> mem_req_addr = 0x1000 + (VA tag<<2); new_tlb_info.phy_addr = {0x5, 0xABC} at cycle 3.
REQ-033 PTE valid=0 -> page_fault one cycle, page_fault_virt_addr = VA, no new_tlb_entry.
REQ-034 mem_req_ready held low for 5 cycles -> mem_req_valid/addr stable throughout; fill 2 cycles after the handshake.
REQ-035 Flush in WAIT, response 3 cycles later -> no fill, no fault, IDLE; next miss serviced normally.
REQ-036 No response for 64 cycles -> page_fault on the timeout cycle; late response ignored.
REQ-037 Reset asserted in WAIT -> all outputs at reset values immediately; miss_ready = 1 after release.
